serial_add_ctrl: RTL



---
 rtl/serial_add_ctrl_pkg.sv | 12 +
 rtl/serial_add_ctrl_if.sv | 25 ++
 rtl/serial_add_ctrl_fa_cell.sv | 27 ++
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand-in / result-out handshake bundle for serial_add_ctrl.
interface serial_add_ctrl_if #(
  parameter int WIDTH = serial_add_pkg::DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// 1-bit full adder built from two half adders; purely combinational.
module ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0;
  logic c0;
  logic c1;

  ha u_ha0 (.x(a),  .y(b),  .s(s0), .c(c0));
  ha u_ha1 (.x(s0), .y(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell stepped LSB-first over WIDTH cycles.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic               clk,
  input logic               rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             out_valid_q;
  logic             last;
  logic             fa_s;
  logic             fa_co;
  logic             in_ready_c;
  logic             busy_c;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // A one-bit sum register has no upper slice to shift down.
  if (WIDTH == 1) begin : g_w1
    assign sum_next = fa_s;
  end else begin : g_wn
    assign sum_next = {fa_s, sum_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (bus.in_valid && in_ready_c) state_nxt = ST_RUN;
      ST_RUN:  if (last)                       state_nxt = ST_DONE;
      ST_DONE: if (out_valid_q && bus.out_ready) state_nxt = ST_IDLE;
      default:                                 state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_c = (state == ST_IDLE);
    busy_c     = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            carry  <= bus.cin;
            cnt    <= '0;
            sum_sr <= '0;
          end
        end
        ST_RUN: begin
          sum_sr <= sum_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= fa_co;
          cnt    <= cnt + CNT_W'(1);
          if (last) out_valid_q <= 1'b1;
        end
        ST_DONE: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_sr;
  assign bus.cout      = carry;

endmodule
